// File: rtl/alu_pkg.sv
// Shared types and constants for the RV32I ALU execute stage.
package alu_pkg;

    // ALU control encoding produced by the decoder
    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluAnd  = 4'd2,
        AluOr   = 4'd3,
        AluXor  = 4'd4,
        AluSlt  = 4'd5,
        AluSltu = 4'd6,
        AluSll  = 4'd7,
        AluSrl  = 4'd8,
        AluSra  = 4'd9,
        AluMul  = 4'd10
    } alu_ctrl_e;

    // Execute-stage FSM states
    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StMul,
        StDone
    } state_e;

    // RV32I opcodes seen by this stage
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // funct7 values accepted for R-type
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // alu_op selector values
    localparam logic [1:0] ALUOP_ADD     = 2'b00;
    localparam logic [1:0] ALUOP_SUB     = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT   = 2'b10;
    localparam logic [1:0] ALUOP_ILLEGAL = 2'b11;

    function automatic logic is_shift(alu_ctrl_e ctrl);
        return (ctrl == AluSll) || (ctrl == AluSrl) || (ctrl == AluSra);
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operation/result handshake bundle between register-read, ALU and writeback.
interface alu_exec_unit_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      op_code;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [1:0]      alu_op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    // Producer of operations / consumer of results
    modport master (
        output in_valid, op_code, funct3, funct7, alu_op, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    // The execute unit itself
    modport slave (
        input  in_valid, op_code, funct3, funct7, alu_op, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_ctrl_dec.sv
// Combinational decode of {op_code, funct7, funct3, alu_op} into an ALU control.
// Multiply decode is built only when ALU_MUL_EN is defined.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [6:0] op_code,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic [1:0] alu_op,
    output alu_ctrl_e  ctrl,
    output logic       illegal
);
    logic r_type;
    logic unused_op_code;

    assign r_type = op_code[5];
    // Only op_code[5] distinguishes R-type from I-type here
    assign unused_op_code = ^{op_code[6], op_code[4:0]};

    // Decode the control; anything not in the table flags illegal
    always_comb begin
        ctrl    = AluAdd;
        illegal = 1'b0;
        unique case (alu_op)
            ALUOP_ADD:     ctrl = AluAdd;
            ALUOP_SUB:     ctrl = AluSub;
            ALUOP_ILLEGAL: illegal = 1'b1;
            default: begin
                if (r_type && funct7 == F7_MULDIV) begin
`ifdef ALU_MUL_EN
                    if (funct3 == 3'b000) ctrl = AluMul;
                    else                  illegal = 1'b1;
`else
                    illegal = 1'b1;
`endif
                end else if (r_type && funct7 != F7_BASE && funct7 != F7_ALT) begin
                    illegal = 1'b1;
                end else begin
                    unique case (funct3)
                        3'b000: ctrl = (r_type && funct7[5]) ? AluSub : AluAdd;
                        3'b001: begin
                            if (funct7[5]) illegal = 1'b1;
                            else           ctrl = AluSll;
                        end
                        3'b010: ctrl = AluSlt;
                        3'b011: ctrl = AluSltu;
                        3'b100: ctrl = AluXor;
                        3'b101: ctrl = funct7[5] ? AluSra : AluSrl;
                        3'b110: ctrl = AluOr;
                        default: ctrl = AluAnd;
                    endcase
                end
            end
        endcase
    end
endmodule

// File: rtl/alu_exec_unit.sv
// RV32I execute stage: single-cycle ALU ops, iterative shifter and (with ALU_MUL_EN)
// an iterative shift-add multiplier behind valid/ready handshakes.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_exec_unit_if.slave bus
);
    localparam int unsigned ShW  = $clog2(XLEN);
    localparam int unsigned ShW1 = ShW + 1;
    localparam logic [ShW:0] StepAmt = ShW1'(SHIFT_STEP);

    state_e          state_q, state_d, accept_state;
    logic            started_q;
    alu_ctrl_e       dec_ctrl, op_q;
    logic            dec_illegal;
    logic            accept;
    logic            in_ready;
    logic [ShW-1:0]  shamt;
    logic            long_shift;
    logic            dec_mul;
    logic [XLEN-1:0] single_res;
    logic [XLEN-1:0] acc_q;
    logic [ShW-1:0]  cnt_q;
    logic [XLEN-1:0] result_q;
    logic            illegal_q;
    logic            last_shift;
    logic [ShW:0]    step_amt;
    logic [XLEN-1:0] shift_res;

    alu_ctrl_dec u_dec (
        .op_code (bus.op_code),
        .funct3  (bus.funct3),
        .funct7  (bus.funct7),
        .alu_op  (bus.alu_op),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    assign shamt      = bus.src_b[ShW-1:0];
    assign long_shift = !dec_illegal && is_shift(dec_ctrl) && (shamt != '0);
    assign accept     = bus.in_valid && in_ready;

`ifdef ALU_MUL_EN
    logic [XLEN-1:0] mcand_q, mplier_q;
    logic [XLEN-1:0] mul_sum;
    logic            mul_last;

    assign dec_mul  = !dec_illegal && (dec_ctrl == AluMul);
    assign mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_last = (cnt_q == '0);

    // Multiplicand shifts left, multiplier shifts right, one bit per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (accept) begin
            mcand_q  <= bus.src_a;
            mplier_q <= bus.src_b;
        end else if (state_q == StMul) begin
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end
`else
    assign dec_mul = 1'b0;
`endif

    // Result of everything that completes on the accept edge
    always_comb begin
        single_res = '0;
        unique case (dec_ctrl)
            AluAdd:  single_res = bus.src_a + bus.src_b;
            AluSub:  single_res = bus.src_a - bus.src_b;
            AluAnd:  single_res = bus.src_a & bus.src_b;
            AluOr:   single_res = bus.src_a | bus.src_b;
            AluXor:  single_res = bus.src_a ^ bus.src_b;
            AluSlt:  single_res = XLEN'($signed(bus.src_a) < $signed(bus.src_b));
            AluSltu: single_res = XLEN'(bus.src_a < bus.src_b);
            // Reached only for a zero shift amount
            AluSll, AluSrl, AluSra: single_res = bus.src_a;
            default: single_res = '0;
        endcase
        if (dec_illegal) single_res = '0;
    end

    // One shifter step of min(SHIFT_STEP, remaining) bits
    always_comb begin
        last_shift = ({1'b0, cnt_q} <= StepAmt);
        step_amt   = last_shift ? {1'b0, cnt_q} : StepAmt;
        unique case (op_q)
            AluSll:  shift_res = acc_q << step_amt;
            AluSrl:  shift_res = acc_q >> step_amt;
            AluSra:  shift_res = XLEN'($signed(acc_q) >>> step_amt);
            default: shift_res = acc_q;
        endcase
    end

    // FSM state register; started_q holds off in_ready until the first edge after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d      = state_q;
        accept_state = dec_mul ? StMul : (long_shift ? StShift : StDone);
        unique case (state_q)
            StIdle:  if (accept) state_d = accept_state;
            StShift: if (last_shift) state_d = StDone;
`ifdef ALU_MUL_EN
            StMul:   if (mul_last) state_d = StDone;
`else
            StMul:   state_d = StIdle;
`endif
            default: begin
                if (accept)             state_d = accept_state;
                else if (bus.out_ready) state_d = StIdle;
            end
        endcase
    end

    // FSM outputs and registered result presentation
    always_comb begin
        in_ready      = started_q &&
                        ((state_q == StIdle) || ((state_q == StDone) && bus.out_ready));
        bus.in_ready  = in_ready;
        bus.out_valid = (state_q == StDone);
        bus.result    = result_q;
        bus.zero      = (result_q == '0);
        bus.illegal   = illegal_q;
    end

    // Datapath: capture on accept, iterate, publish the result only on completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= AluAdd;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            op_q  <= dec_ctrl;
            acc_q <= dec_mul ? '0 : bus.src_a;
            cnt_q <= dec_mul ? ShW'(XLEN - 1) : shamt;
            if (!dec_mul && !long_shift) begin
                result_q  <= single_res;
                illegal_q <= dec_illegal;
            end
        end else if (state_q == StShift) begin
            acc_q <= shift_res;
            cnt_q <= cnt_q - step_amt[ShW-1:0];
            if (last_shift) begin
                result_q  <= shift_res;
                illegal_q <= 1'b0;
            end
`ifdef ALU_MUL_EN
        end else if (state_q == StMul) begin
            acc_q <= mul_sum;
            cnt_q <= cnt_q - 1'b1;
            if (mul_last) begin
                result_q  <= mul_sum;
                illegal_q <= 1'b0;
            end
`endif
        end
    end
endmodule
